// File: rtl/flash_writer.sv
// SPI NOR flash page writer for a DFU download stream.
// Erases 4 KiB sectors on entry, programs 256-byte pages, polls WIP.
module flash_writer #(
  parameter logic [23:0] START_ADDR = 24'h020000,
  parameter logic [23:0] END_ADDR   = 24'h100000,
  parameter int unsigned POLL_LIMIT = 200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       out_en_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  input  logic       clear_status_i,
  output logic       busy_o,
  output logic [3:0] status_o,
  output logic       sck_o,
  output logic       csn_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN,
    S_ERASE,
    S_POLL_E,
    S_WREN_P,
    S_PROG_HDR,
    S_PROG_DATA,
    S_POLL_P,
    S_DISCARD
  } state_e;

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [1:0]    hold_q;
  logic          csn_q;
  logic [23:0]   addr_q;
  logic [3:0]    status_q;
  logic [PW-1:0] poll_q;
  logic          page_end_q;

  logic          spi_busy_q;
  logic [3:0]    spi_cnt_q;
  logic [6:0]    spi_tx_q;
  logic          spi_rx_q;
  logic          sck_q;
  logic          mosi_q;

  logic          can_act;
  logic          spi_go;
  logic [7:0]    spi_byte;
  logic [7:0]    hdr_byte;
  logic          poll_over;

  assign poll_over   = (poll_q == PW'(POLL_LIMIT - 1));
  assign busy_o      = (state_q != S_IDLE);
  assign status_o    = status_q;
  assign csn_o       = csn_q;
  assign sck_o       = sck_q;
  assign mosi_o      = mosi_q;
  assign out_ready_o = (state_q == S_DISCARD) ||
                       ((state_q == S_PROG_DATA) &&
                        !spi_busy_q && !page_end_q);

  always_comb begin
    can_act  = (hold_q == 2'd0) && !spi_busy_q;
    spi_go   = 1'b0;
    spi_byte = 8'h00;
    hdr_byte = 8'h00;
    case (idx_q)
      3'd0:    hdr_byte = (state_q == S_ERASE) ? 8'h20 : 8'h02;
      3'd1:    hdr_byte = addr_q[23:16];
      3'd2:    hdr_byte = addr_q[15:8];
      3'd3:    hdr_byte = addr_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
    unique case (state_q)
      S_WREN, S_WREN_P: begin
        if (can_act && idx_q == 3'd0) begin
          spi_go   = 1'b1;
          spi_byte = 8'h06;
        end
      end
      S_ERASE, S_PROG_HDR: begin
        if (can_act && idx_q != 3'd4) begin
          spi_go   = 1'b1;
          spi_byte = hdr_byte;
        end
      end
      S_POLL_E, S_POLL_P: begin
        // Index 2 means a status byte has just been read.
        if (can_act) begin
          if (idx_q == 3'd0) begin
            spi_go   = 1'b1;
            spi_byte = 8'h05;
          end else if (idx_q == 3'd1 ||
                       (spi_rx_q && !poll_over)) begin
            spi_go   = 1'b1;
            spi_byte = 8'h00;
          end
        end
      end
      S_PROG_DATA: begin
        if (!spi_busy_q && !page_end_q && out_valid_i) begin
          spi_go   = 1'b1;
          spi_byte = out_data_i;
        end
      end
      default: begin
        spi_go = 1'b0;
      end
    endcase
  end

  // Mode-0 shifter: even counts raise SCK and sample, odd counts drop it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spi_busy_q <= 1'b0;
      spi_cnt_q  <= 4'd0;
      spi_tx_q   <= 7'd0;
      spi_rx_q   <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else if (spi_go) begin
      spi_busy_q <= 1'b1;
      spi_cnt_q  <= 4'd0;
      spi_tx_q   <= spi_byte[6:0];
      mosi_q     <= spi_byte[7];
      sck_q      <= 1'b0;
    end else if (spi_busy_q) begin
      spi_cnt_q <= spi_cnt_q + 4'd1;
      if (!spi_cnt_q[0]) begin
        sck_q    <= 1'b1;
        spi_rx_q <= miso_i;
      end else begin
        sck_q    <= 1'b0;
        spi_tx_q <= {spi_tx_q[5:0], 1'b0};
        if (spi_cnt_q == 4'd15) begin
          mosi_q     <= 1'b0;
          spi_busy_q <= 1'b0;
        end else begin
          mosi_q <= spi_tx_q[6];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      hold_q     <= 2'd0;
      csn_q      <= 1'b1;
      addr_q     <= START_ADDR;
      status_q   <= 4'h0;
      poll_q     <= '0;
      page_end_q <= 1'b0;
    end else begin
      if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
      if (spi_go) csn_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= START_ADDR;
          end else if (clear_status_i) begin
            status_q <= 4'h0;
          end else if (out_valid_i && out_en_i) begin
            hold_q <= 2'd2;
            idx_q  <= 3'd0;
            if (status_q != 4'h0) begin
              state_q <= S_DISCARD;
            end else if (addr_q >= END_ADDR) begin
              state_q  <= S_DISCARD;
              status_q <= 4'h8;
            end else if (addr_q[11:0] == 12'h000) begin
              state_q <= S_WREN;
            end else begin
              state_q <= S_WREN_P;
            end
          end
        end
        S_WREN, S_WREN_P: begin
          if (can_act) begin
            if (idx_q == 3'd0) begin
              idx_q <= 3'd1;
            end else begin
              csn_q   <= 1'b1;
              hold_q  <= 2'd2;
              idx_q   <= 3'd0;
              state_q <= (state_q == S_WREN) ? S_ERASE
                                             : S_PROG_HDR;
            end
          end
        end
        S_ERASE: begin
          if (can_act) begin
            if (idx_q != 3'd4) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              csn_q   <= 1'b1;
              hold_q  <= 2'd2;
              idx_q   <= 3'd0;
              state_q <= S_POLL_E;
            end
          end
        end
        S_PROG_HDR: begin
          if (can_act) begin
            if (idx_q != 3'd4) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              idx_q      <= 3'd0;
              page_end_q <= 1'b0;
              state_q    <= S_PROG_DATA;
            end
          end
        end
        S_POLL_E, S_POLL_P: begin
          if (can_act) begin
            if (idx_q != 3'd2) begin
              idx_q <= idx_q + 3'd1;
            end else if (!spi_rx_q) begin
              csn_q   <= 1'b1;
              hold_q  <= 2'd2;
              idx_q   <= 3'd0;
              poll_q  <= '0;
              state_q <= (state_q == S_POLL_E) ? S_WREN_P
                                               : S_IDLE;
            end else if (poll_over) begin
              csn_q    <= 1'b1;
              hold_q   <= 2'd2;
              idx_q    <= 3'd0;
              poll_q   <= '0;
              status_q <= (state_q == S_POLL_E) ? 4'h4 : 4'h3;
              state_q  <= S_IDLE;
            end else begin
              poll_q <= poll_q + PW'(1);
            end
          end
        end
        S_PROG_DATA: begin
          if (!spi_busy_q) begin
            if (page_end_q || (!out_valid_i && !out_en_i)) begin
              csn_q      <= 1'b1;
              hold_q     <= 2'd2;
              idx_q      <= 3'd0;
              page_end_q <= 1'b0;
              state_q    <= S_POLL_P;
            end else if (out_valid_i) begin
              addr_q     <= addr_q + 24'd1;
              page_end_q <= (addr_q[7:0] == 8'hFF);
            end
          end
        end
        S_DISCARD: begin
          if (!out_en_i) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer with a sniffing SPI flash model.
// The model reports WIP for two status reads after erase/program.
module tb_flash_writer;

  localparam logic [23:0] ST  = 24'h020000;
  localparam logic [23:0] EA  = 24'h020200;
  localparam int unsigned PL  = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       out_en_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       clear_status_i = 1'b0;
  logic       out_ready_o;
  logic       busy_o;
  logic [3:0] status_o;
  logic       sck_o;
  logic       csn_o;
  logic       mosi_o;
  logic       miso_i;

  flash_writer #(
    .START_ADDR(ST),
    .END_ADDR(EA),
    .POLL_LIMIT(PL)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .out_en_i(out_en_i),
    .out_data_i(out_data_i),
    .out_valid_i(out_valid_i),
    .out_ready_o(out_ready_o),
    .clear_status_i(clear_status_i),
    .busy_o(busy_o),
    .status_o(status_o),
    .sck_o(sck_o),
    .csn_o(csn_o),
    .mosi_o(mosi_o),
    .miso_i(miso_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  sh = 8'h00;
  logic [7:0]  first = 8'h00;
  int          bitc = 0;
  int          fbytes = 0;
  int          wip_left = 0;
  bit          stuck = 1'b0;
  bit          csn_low_seen = 1'b0;
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  assign miso_i = (!csn_o && fbytes >= 1 && first == 8'h05 &&
                   bitc == 7) ? (stuck || wip_left > 0) : 1'b0;

  always @(posedge sck_o) begin
    if (!csn_o) begin
      sh = {sh[6:0], mosi_o};
      bitc++;
      if (bitc == 8) begin
        log_q.push_back({8'h00, sh});
        if (fbytes == 0) first = sh;
        else if (first == 8'h05 && wip_left > 0) wip_left--;
        fbytes++;
        bitc = 0;
      end
    end
  end

  always @(posedge csn_o) begin
    if (fbytes > 0) begin
      log_q.push_back(16'h0100);
      if (first == 8'h20 || first == 8'h02) wip_left = 2;
    end
    fbytes = 0;
    bitc = 0;
  end

  always @(negedge csn_o) csn_low_seen = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit done;
    done = 1'b0;
    out_data_i  = d;
    out_valid_i = 1'b1;
    for (int t = 0; t < 4000 && !done; t++) begin
      if (out_ready_o) begin
        @(posedge clk_i);
        done = 1'b1;
      end
      @(negedge clk_i);
    end
    out_valid_i = 1'b0;
    if (!done) check("handshake_timeout", 32'(done), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o && t < 20000) begin
      @(negedge clk_i);
      t++;
    end
    check("idle_timeout", 32'(busy_o), 0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic ex(input logic [7:0] b);
    exp_q.push_back({8'h00, b});
  endtask

  task automatic eof();
    exp_q.push_back(16'h0100);
  endtask

  task automatic ex_cmd(input logic [7:0] op, input logic [23:0] a);
    ex(op);
    ex(a[23:16]);
    ex(a[15:8]);
    ex(a[7:0]);
  endtask

  task automatic ex_poll(input int n);
    ex(8'h05);
    repeat (n) ex(8'h00);
    eof();
  endtask

  task automatic ex_erase(input logic [23:0] a);
    ex(8'h06); eof();
    ex_cmd(8'h20, a); eof();
    ex_poll(3);
  endtask

  task automatic cmp_log(input string tag);
    int bad;
    int n;
    bad = 0;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++)
      if (log_q[i] !== exp_q[i]) bad++;
    check({tag, "_bytes"}, 32'(bad), 0);
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_csn", 32'(csn_o), 1);
    check("rst_sck", 32'(sck_o), 0);
    check("rst_mosi", 32'(mosi_o), 0);
    check("rst_ready", 32'(out_ready_o), 0);
    check("rst_status", 32'(status_o), 0);
    check("rst_addr", 32'(dut.addr_q), 32'(ST));
    rst_i = 1'b0;
    tick(2);

    // Full first page: erase then program.
    pulse_start();
    out_en_i = 1'b1;
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_idle();
    ex_erase(ST);
    ex(8'h06); eof();
    ex_cmd(8'h02, ST);
    for (int i = 0; i < 256; i++) ex(8'(i));
    eof();
    ex_poll(3);
    cmp_log("page0");
    check("page0_status", 32'(status_o), 0);
    check("page0_addr", 32'(dut.addr_q), 32'h020100);

    // Second page: no erase, stall mid-page, start ignored while busy.
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i * 3 + 7));
      if (i == 100) begin
        tick(30);
        check("gap_csn", 32'(csn_o), 0);
        check("gap_sck", 32'(sck_o), 0);
        check("gap_ready", 32'(out_ready_o), 1);
        pulse_start();
      end
    end
    wait_idle();
    ex(8'h06); eof();
    ex_cmd(8'h02, 24'h020100);
    for (int i = 0; i < 256; i++) ex(8'(i * 3 + 7));
    eof();
    ex_poll(3);
    cmp_log("page1");
    check("page1_addr", 32'(dut.addr_q), 32'h020200);

    // Address at END_ADDR: errADDRESS, bytes dropped, no SPI.
    csn_low_seen = 1'b0;
    send_byte(8'h55);
    check("end_status", 32'(status_o), 32'h8);
    check("end_busy", 32'(busy_o), 1);
    clear_status_i = 1'b1;
    tick(1);
    clear_status_i = 1'b0;
    check("clr_busy_ignored", 32'(status_o), 32'h8);
    send_byte(8'h56);
    send_byte(8'h57);
    out_en_i = 1'b0;
    wait_idle();
    check("end_status_kept", 32'(status_o), 32'h8);
    check("end_no_csn", 32'(csn_low_seen), 0);
    check("end_no_spi", 32'(log_q.size()), 0);
    clear_status_i = 1'b1;
    tick(1);
    clear_status_i = 1'b0;
    check("clr_idle", 32'(status_o), 0);

    // start_i with a byte in the same cycle, then a short page.
    out_en_i    = 1'b1;
    out_data_i  = 8'hA0;
    out_valid_i = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    out_en_i = 1'b0;
    wait_idle();
    ex_erase(ST);
    ex(8'h06); eof();
    ex_cmd(8'h02, ST);
    for (int i = 0; i < 10; i++) ex(8'(8'hA0 + i));
    eof();
    ex_poll(3);
    cmp_log("short");
    check("short_status", 32'(status_o), 0);
    check("short_addr", 32'(dut.addr_q), 32'h02000A);

    // Erase never finishes: errERASE after POLL_LIMIT reads.
    stuck = 1'b1;
    pulse_start();
    out_en_i = 1'b1;
    send_byte(8'hAA);
    check("erase_err_status", 32'(status_o), 32'h4);
    check("erase_err_busy", 32'(busy_o), 1);
    check("erase_err_ready", 32'(out_ready_o), 1);
    send_byte(8'hBB);
    ex(8'h06); eof();
    ex_cmd(8'h20, ST); eof();
    ex_poll(PL);
    cmp_log("erase_err");
    out_en_i = 1'b0;
    wait_idle();
    check("erase_err_kept", 32'(status_o), 32'h4);
    stuck = 1'b0;
    out_en_i = 1'b1;
    send_byte(8'hCC);
    check("sticky_no_spi", 32'(log_q.size()), 0);
    check("sticky_status", 32'(status_o), 32'h4);
    out_en_i = 1'b0;
    wait_idle();
    clear_status_i = 1'b1;
    tick(1);
    clear_status_i = 1'b0;
    check("clr_erase_err", 32'(status_o), 0);

    // Reset in the middle of a data byte.
    pulse_start();
    out_en_i = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
    tick(3);
    check("mid_csn", 32'(csn_o), 0);
    rst_i = 1'b1;
    tick(1);
    check("abort_csn", 32'(csn_o), 1);
    check("abort_busy", 32'(busy_o), 0);
    check("abort_sck", 32'(sck_o), 0);
    check("abort_addr", 32'(dut.addr_q), 32'(ST));
    rst_i = 1'b0;
    out_en_i = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
